// File: rtl/multi_digit_counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the multi-digit BCD counter family.
//   - seg_bits_t   : 7-segment bit order, packed {g,f,e,d,c,b,a}, active-high
//   - SEG_0..SEG_9 : segment codes for decimal digits
//   - SEG_BLANK    : all segments off
//   - BCD_MAX_DIGIT: largest legal BCD nibble
//   - int_to_bcd() : elaboration-time integer -> packed BCD (8 digits)
//   - pow10()      : elaboration-time power of ten for range checks
// -----------------------------------------------------------------------------
package counter_pkg;

    // Segment bit order: bit 6 = g ... bit 0 = a.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_bits_t;

    localparam seg_bits_t SEG_0     = 7'h3F;
    localparam seg_bits_t SEG_1     = 7'h06;
    localparam seg_bits_t SEG_2     = 7'h5B;
    localparam seg_bits_t SEG_3     = 7'h4F;
    localparam seg_bits_t SEG_4     = 7'h66;
    localparam seg_bits_t SEG_5     = 7'h6D;
    localparam seg_bits_t SEG_6     = 7'h7D;
    localparam seg_bits_t SEG_7     = 7'h07;
    localparam seg_bits_t SEG_8     = 7'h7F;
    localparam seg_bits_t SEG_9     = 7'h6F;
    localparam seg_bits_t SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Converts a non-negative integer into up to eight packed BCD digits,
    // digit 0 in [3:0]. Used only on parameters.
    function automatic logic [31:0] int_to_bcd(input int unsigned value);
        logic [31:0] res;
        int unsigned v;
        res = '0;
        v   = value;
        for (int unsigned i = 0; i < 8; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return res;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_digit_counter_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//   Decodes one BCD nibble to active-high 7-segment drive {g,f,e,d,c,b,a}.
//   Ports:
//     bcd      in  [3:0] BCD digit; values above 9 decode to all-off
//     blank    in        forces all segments off (leading-zero blanking)
//     segments out [6:0] segment drive
// -----------------------------------------------------------------------------
module seven_seg_decoder
    import counter_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    segments = SEG_0;
                4'd1:    segments = SEG_1;
                4'd2:    segments = SEG_2;
                4'd3:    segments = SEG_3;
                4'd4:    segments = SEG_4;
                4'd5:    segments = SEG_5;
                4'd6:    segments = SEG_6;
                4'd7:    segments = SEG_7;
                4'd8:    segments = SEG_8;
                4'd9:    segments = SEG_9;
                default: segments = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/multi_digit_counter.sv
// -----------------------------------------------------------------------------
// multi_digit_counter
//   N-digit BCD up/down counter with programmable modulus, clock-enable
//   prescaler, validated parallel load, wrap pulse and per-digit 7-segment
//   decode with optional leading-zero blanking.
//   Parameters:
//     DIGITS    number of BCD digits (1..8)
//     MAX_VALUE count range 0..MAX_VALUE (must fit in DIGITS decimal digits)
//     TICK_DIV  enabled clock cycles per count step (>= 1)
//     BLANK_LZ  1 = blank leading zero digits above digit 0
//   Ports:
//     clock      in   system clock, rising edge
//     reset      in   asynchronous active-high reset
//     enable     in   count enable, gates the prescaler
//     up_down    in   1 = up, 0 = down
//     load       in   synchronous load request (priority over tick)
//     load_value in   BCD load value, digit 0 in [3:0]
//     bcd        out  registered count, BCD
//     segments   out  7-seg drive, digit k in [7k+6:7k]
//     wrap       out  one-cycle pulse on modulus wrap
//     load_err   out  one-cycle pulse on rejected load
// -----------------------------------------------------------------------------
module multi_digit_counter
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned MAX_VALUE = 99,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned BLANK_LZ  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  wrap,
    output logic                  load_err
);

    // ---------------------------------------------------------------- checks
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "multi_digit_counter: DIGITS must be 1..8");
    end
    if (64'(MAX_VALUE) >= pow10(DIGITS)) begin : g_bad_max
        $fatal(1, "multi_digit_counter: MAX_VALUE out of range for DIGITS");
    end
    if (TICK_DIV == 0) begin : g_bad_div
        $fatal(1, "multi_digit_counter: TICK_DIV must be >= 1");
    end

    // ------------------------------------------------------------- constants
    localparam logic [31:0]         MAX_BCD_FULL = int_to_bcd(MAX_VALUE);
    localparam logic [4*DIGITS-1:0] MAX_BCD      = MAX_BCD_FULL[4*DIGITS-1:0];
    localparam int unsigned         PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]       PRESC_LAST   = PW'(TICK_DIV - 1);

    // ----------------------------------------------------------------- state
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;

    logic                tick;
    logic                load_ok;
    logic [4*DIGITS-1:0] bcd_inc;
    logic [4*DIGITS-1:0] bcd_dec;
    logic [DIGITS-1:0]   blank;

    assign tick = enable && (presc_q == PRESC_LAST);

    // Valid BCD values order the same way as their binary encodings, so the
    // modulus check is a plain unsigned compare once every nibble is <= 9.
    always_comb begin
        logic digits_ok;
        digits_ok = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (load_value[4*k +: 4] > BCD_MAX_DIGIT) begin
                digits_ok = 1'b0;
            end
        end
        load_ok = digits_ok && (load_value <= MAX_BCD);
    end

    // Ripple-carry BCD increment.
    always_comb begin
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (bcd_q[4*k +: 4] == BCD_MAX_DIGIT) begin
                    bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Ripple-borrow BCD decrement.
    always_comb begin
        logic borrow;
        bcd_dec = bcd_q;
        borrow  = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (bcd_q[4*k +: 4] == 4'd0) begin
                    bcd_dec[4*k +: 4] = BCD_MAX_DIGIT;
                end else begin
                    bcd_dec[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Next state: load has priority; a rejected load also swallows the tick
    // and leaves the prescaler where it was.
    always_comb begin
        bcd_d      = bcd_q;
        presc_d    = presc_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                bcd_d   = load_value;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable) begin
            if (tick) begin
                presc_d = '0;
                if (up_down) begin
                    if (bcd_q == MAX_BCD) begin
                        bcd_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        bcd_d = bcd_inc;
                    end
                end else begin
                    if (bcd_q == '0) begin
                        bcd_d  = MAX_BCD;
                        wrap_d = 1'b1;
                    end else begin
                        bcd_d = bcd_dec;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcd_q      <= '0;
            presc_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            presc_q    <= presc_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Walk from the top digit down; a digit is blanked while it and every
    // digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            upper_zero = upper_zero && (bcd_q[4*(DIGITS-1-i) +: 4] == 4'd0);
            if (BLANK_LZ != 0 && (DIGITS - 1 - i) != 0) begin
                blank[DIGITS-1-i] = upper_zero;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seven_seg_decoder u_dec (
            .bcd      (bcd_q[4*g +: 4]),
            .blank    (blank[g]),
            .segments (segments[7*g +: 7])
        );
    end

    assign bcd      = bcd_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule
